// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, issue FSM states and operand helpers
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_XOR     = 4'd4,
        OP_SLT     = 4'd5,
        OP_SLTU    = 4'd6,
        OP_SLL     = 4'd8,
        OP_SRL     = 4'd12,
        OP_SRA     = 4'd13,
        OP_ILLEGAL = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} issue_state_e;

    function automatic logic is_shift(alu_op_e op);
        return op inside {OP_SLL, OP_SRL, OP_SRA};
    endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational funct3/funct7 decode and second-operand formatting
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        is_imm,
    input  logic [31:0] rs2_dat,
    input  logic [31:0] imm_dat,
    output alu_op_e     op,
    output logic [31:0] dat2
);
    logic [31:0] src;

    always_comb begin
        case (funct3)
            3'b000:  op = (funct7_b5 && !is_imm) ? OP_SUB : OP_ADD;
            3'b001:  op = funct7_b5 ? OP_ILLEGAL : OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7_b5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
    end

    assign src  = is_imm ? imm_dat : rs2_dat;
    // shift units only consume the 5-bit shift amount
    assign dat2 = is_shift(op) ? {27'b0, src[4:0]} : src;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one decoded ALU op, issues operands for one cycle,
// captures the unit result and holds it until writeback accepts it
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        is_imm,
    input  logic [31:0] rs1_dat,
    input  logic [31:0] rs2_dat,
    input  logic [31:0] imm_dat,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [2:0]  ALU_opcode,
    output logic [3:0]  decryptedOP,
    input  logic [31:0] unit_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_illegal,
    output logic [15:0] op_count
);
    issue_state_e state;
    alu_op_e      dec_op;
    logic [31:0]  dec_dat2;

    alu_op_decode u_dec (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .is_imm    (is_imm),
        .rs2_dat   (rs2_dat),
        .imm_dat   (imm_dat),
        .op        (dec_op),
        .dat2      (dec_dat2)
    );

    assign in_ready = state == S_IDLE;

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            dat_ready   <= 1'b0;
            ALU_dat1    <= '0;
            ALU_dat2    <= '0;
            ALU_opcode  <= '0;
            decryptedOP <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    ALU_dat1    <= rs1_dat;
                    ALU_dat2    <= dec_dat2;
                    ALU_opcode  <= funct3;
                    decryptedOP <= dec_op;
                    // illegal ops skip the execution units and answer at once
                    if (dec_op == OP_ILLEGAL) begin
                        state       <= S_RESP;
                        res_valid   <= 1'b1;
                        res_data    <= '0;
                        res_illegal <= 1'b1;
                    end else begin
                        state       <= S_ISSUE;
                        dat_ready   <= 1'b1;
                        res_illegal <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    dat_ready <= 1'b0;
                    op_count  <= op_count + 16'd1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    res_data  <= unit_result;
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                default: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of the ALU issue controller
module tb_alu_issue_ctrl;
    logic        soc_clk = 1'b0;
    logic        reset, in_valid, in_ready, funct7_b5, is_imm, dat_ready;
    logic [2:0]  funct3, ALU_opcode;
    logic [31:0] rs1_dat, rs2_dat, imm_dat, ALU_dat1, ALU_dat2, unit_result, res_data;
    logic [3:0]  decryptedOP;
    logic        res_valid, res_ready, res_illegal;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    int          lat, dr_n, dr_cyc;
    logic [31:0] o1, o2, ores, u2;
    logic [3:0]  oop;
    logic [2:0]  oopc;
    logic        oill, stable, busy_rdy, bubble_ok;

    alu_issue_ctrl dut (
        .soc_clk(soc_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7_b5(funct7_b5), .is_imm(is_imm),
        .rs1_dat(rs1_dat), .rs2_dat(rs2_dat), .imm_dat(imm_dat),
        .dat_ready(dat_ready), .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
        .ALU_opcode(ALU_opcode), .decryptedOP(decryptedOP), .unit_result(unit_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_illegal(res_illegal), .op_count(op_count)
    );

    always #5 soc_clk = ~soc_clk;

    // decode table from the operation list: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND
    function automatic int m_op(logic [2:0] f3, logic b5, logic im);
        int t [8];
        t = '{(b5 && !im) ? 1 : 0, b5 ? 15 : 8, 5, 6, 4, b5 ? 13 : 12, 3, 2};
        return t[f3];
    endfunction

    function automatic logic [31:0] m_dat2(int op, logic im, logic [31:0] b, logic [31:0] c);
        logic [31:0] s;
        s = im ? c : b;
        return (op == 8 || op == 12 || op == 13) ? s % 32 : s;
    endfunction

    task automatic scramble();
        in_valid = 1'($urandom); funct3 = 3'($urandom); funct7_b5 = 1'($urandom);
        is_imm = 1'($urandom); rs1_dat = $urandom; rs2_dat = $urandom; imm_dat = $urandom;
        unit_result = $urandom;
    endtask

    // drives one operation from IDLE through the writeback handshake and records what was seen
    task automatic do_op(input logic [2:0] f3, input logic b5, input logic im,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int hold);
        lat = -1; dr_n = 0; dr_cyc = -1; stable = 1; busy_rdy = 0; u2 = 0; ores = 'x; oill = 'x;
        in_valid = 1; funct3 = f3; funct7_b5 = b5; is_imm = im;
        rs1_dat = a; rs2_dat = b; imm_dat = c; res_ready = 0;
        @(negedge soc_clk);
        for (int t = 1; t <= 8 && lat < 0; t++) begin
            if (dat_ready) begin dr_n++; if (dr_cyc < 0) dr_cyc = t; end
            if (in_ready) busy_rdy = 1;
            if (t == 1) begin o1 = ALU_dat1; o2 = ALU_dat2; oop = decryptedOP; oopc = ALU_opcode; end
            if (res_valid) begin
                lat = t; ores = res_data; oill = res_illegal;
            end else begin
                scramble();
                if (t == 2) u2 = unit_result;
                @(negedge soc_clk);
            end
        end
        for (int h = 0; h < hold; h++) begin
            scramble();
            in_valid = 1;
            @(negedge soc_clk);
            if (!res_valid || res_data !== ores || res_illegal !== oill || in_ready || dat_ready ||
                ALU_dat1 !== o1 || ALU_dat2 !== o2 || decryptedOP !== oop || ALU_opcode !== oopc)
                stable = 0;
        end
        in_valid = 1; funct3 = 3'b000; funct7_b5 = 0; is_imm = 0; res_ready = 1;
        @(negedge soc_clk);
        bubble_ok = in_ready && !res_valid && !dat_ready;
        in_valid = 0; res_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; res_ready = 1; funct3 = 0; funct7_b5 = 0; is_imm = 0;
        rs1_dat = 32'h1234; rs2_dat = 32'h5678; imm_dat = 32'h9abc; unit_result = 32'hffff_ffff;
        repeat (2) @(negedge soc_clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
        checks++; if (dat_ready !== 1'b0) begin errors++; $display("FAIL reset dat_ready: got %b exp 0", dat_ready); end
        checks++; if (ALU_dat1 !== 0 || ALU_dat2 !== 0) begin errors++; $display("FAIL reset operands: got %h %h exp 0 0", ALU_dat1, ALU_dat2); end
        checks++; if (ALU_opcode !== 0 || decryptedOP !== 0) begin errors++; $display("FAIL reset opcodes: got %h %h exp 0 0", ALU_opcode, decryptedOP); end
        checks++; if (res_valid !== 0 || res_data !== 0 || res_illegal !== 0) begin errors++; $display("FAIL reset result: got %b %h %b exp 0 0 0", res_valid, res_data, res_illegal); end
        checks++; if (op_count !== 0) begin errors++; $display("FAIL reset op_count: got %h exp 0", op_count); end
        reset = 0; in_valid = 0; res_ready = 0; exp_cnt = 0;
    endtask

    task automatic test_add();
        do_op(3'b000, 0, 0, 32'd5, 32'd7, 32'd99, 0);
        exp_cnt++;
        checks++; if (oop !== 4'd0) begin errors++; $display("FAIL add decryptedOP: got %0d exp 0", oop); end
        checks++; if (o1 !== 32'd5 || o2 !== 32'd7) begin errors++; $display("FAIL add operands: got %0d %0d exp 5 7", o1, o2); end
        checks++; if (dr_cyc !== 1 || dr_n !== 1) begin errors++; $display("FAIL add dat_ready: got cycle %0d count %0d exp 1 1", dr_cyc, dr_n); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL add latency: got %0d exp 3", lat); end
        checks++; if (ores !== u2) begin errors++; $display("FAIL add res_data: got %h exp %h", ores, u2); end
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL add op_count: got %0d exp %0d", op_count, exp_cnt); end
    endtask

    task automatic test_srai();
        do_op(3'b101, 1, 1, 32'h8000_0000, $urandom, 32'h0000_0423, 0);
        exp_cnt++;
        checks++; if (o2 !== 32'h3) begin errors++; $display("FAIL srai ALU_dat2: got %h exp 00000003", o2); end
        checks++; if (oop !== 4'd13) begin errors++; $display("FAIL srai decryptedOP: got %0d exp 13", oop); end
        checks++; if (o1 !== 32'h8000_0000 || oopc !== 3'b101) begin errors++; $display("FAIL srai dat1/opcode: got %h %0d exp 80000000 5", o1, oopc); end
    endtask

    task automatic test_illegal();
        do_op(3'b001, 1, 0, $urandom, $urandom, $urandom, 0);
        checks++; if (dr_n !== 0) begin errors++; $display("FAIL illegal dat_ready: got %0d pulses exp 0", dr_n); end
        checks++; if (oill !== 1'b1 || ores !== 0) begin errors++; $display("FAIL illegal result: got ill %b data %h exp 1 0", oill, ores); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal latency: got %0d exp 1", lat); end
        checks++; if (oop !== 4'd15) begin errors++; $display("FAIL illegal decryptedOP: got %0d exp 15", oop); end
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL illegal op_count: got %0d exp %0d", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        do_op(3'b100, 0, 0, $urandom, $urandom, $urandom, 4);
        exp_cnt++;
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL backpressure stable: got %b exp 1", stable); end
        checks++; if (busy_rdy !== 1'b0) begin errors++; $display("FAIL backpressure in_ready: got %b exp 0", busy_rdy); end
        checks++; if (bubble_ok !== 1'b1) begin errors++; $display("FAIL backpressure bubble: got %b exp 1", bubble_ok); end
        checks++; if (ores !== u2) begin errors++; $display("FAIL backpressure res_data: got %h exp %h", ores, u2); end
    endtask

    task automatic test_reset_in_wait();
        logic bad;
        bad = 0;
        in_valid = 1; funct3 = 3'b000; funct7_b5 = 0; is_imm = 0; rs1_dat = 1; rs2_dat = 2;
        @(negedge soc_clk);
        in_valid = 0;
        @(negedge soc_clk);
        reset = 1; in_valid = 1; res_ready = 1; unit_result = 32'hdead_beef;
        @(negedge soc_clk);
        reset = 0; in_valid = 0; res_ready = 0; exp_cnt = 0;
        checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || dat_ready !== 1'b0) begin errors++; $display("FAIL wait-reset state: got rdy %b vld %b dr %b exp 1 0 0", in_ready, res_valid, dat_ready); end
        checks++; if (ALU_dat1 !== 0 || ALU_dat2 !== 0 || ALU_opcode !== 0 || decryptedOP !== 0) begin errors++; $display("FAIL wait-reset operands: got %h %h %h %h exp 0", ALU_dat1, ALU_dat2, ALU_opcode, decryptedOP); end
        checks++; if (res_data !== 0 || res_illegal !== 0 || op_count !== 0) begin errors++; $display("FAIL wait-reset result: got %h %b %h exp 0 0 0", res_data, res_illegal, op_count); end
        repeat (4) begin
            @(negedge soc_clk);
            if (res_valid || dat_ready || !in_ready) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wait-reset quiet: got activity %b exp 0", bad); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic        b5, im, ill;
            logic [31:0] a, b, c;
            int          e;
            f3 = 3'($urandom); b5 = 1'($urandom); im = 1'($urandom);
            a = $urandom; b = $urandom; c = $urandom;
            e = m_op(f3, b5, im);
            ill = e == 15;
            do_op(f3, b5, im, a, b, c, $urandom_range(0, 3));
            if (!ill) exp_cnt++;
            checks++; if (oop !== 4'(e)) begin errors++; $display("FAIL rnd%0d decryptedOP: got %0d exp %0d", i, oop, e); end
            checks++; if (oopc !== f3) begin errors++; $display("FAIL rnd%0d ALU_opcode: got %0d exp %0d", i, oopc, f3); end
            checks++; if (o1 !== a) begin errors++; $display("FAIL rnd%0d ALU_dat1: got %h exp %h", i, o1, a); end
            checks++; if (o2 !== m_dat2(e, im, b, c)) begin errors++; $display("FAIL rnd%0d ALU_dat2: got %h exp %h", i, o2, m_dat2(e, im, b, c)); end
            checks++; if (lat !== (ill ? 1 : 3)) begin errors++; $display("FAIL rnd%0d latency: got %0d exp %0d", i, lat, ill ? 1 : 3); end
            checks++; if (dr_n !== (ill ? 0 : 1)) begin errors++; $display("FAIL rnd%0d dat_ready pulses: got %0d exp %0d", i, dr_n, ill ? 0 : 1); end
            checks++; if (ores !== (ill ? 32'd0 : u2)) begin errors++; $display("FAIL rnd%0d res_data: got %h exp %h", i, ores, ill ? 32'd0 : u2); end
            checks++; if (oill !== ill) begin errors++; $display("FAIL rnd%0d res_illegal: got %b exp %b", i, oill, ill); end
            checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL rnd%0d op_count: got %0d exp %0d", i, op_count, exp_cnt); end
            checks++; if (stable !== 1'b1 || busy_rdy !== 1'b0) begin errors++; $display("FAIL rnd%0d hold: got stable %b busy_rdy %b exp 1 0", i, stable, busy_rdy); end
            checks++; if (bubble_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d bubble: got %b exp 1", i, bubble_ok); end
        end
    endtask

    // stands in for 65535 prior legal issues, which would take far too many cycles to replay
    task automatic test_wrap();
        force dut.op_count = 16'hffff;
        #1;
        release dut.op_count;
        exp_cnt = 16'hffff;
        do_op(3'b110, 0, 1, $urandom, $urandom, $urandom, 0);
        exp_cnt++;
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL wrap op_count: got %h exp %h", op_count, exp_cnt); end
        do_op(3'b111, 1, 0, $urandom, $urandom, $urandom, 1);
        exp_cnt++;
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL wrap next op_count: got %h exp %h", op_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_illegal();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits.
REQ-002 soc_clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decoder presents an ALU operation.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 funct3  input  3  instruction funct3 field.
REQ-007 funct7_b5  input  1  instruction bit 30 (SUB/SRA select).
REQ-008 is_imm  input  1  second operand is the immediate, not rs2.
REQ-009 rs1_dat, rs2_dat, imm_dat  input  32 each  source operands.
REQ-010 dat_ready  output  1  operands valid to execution units.
REQ-011 ALU_dat1, ALU_dat2  output  32 each  formatted operands to execution units.
REQ-012 ALU_opcode  output  3  registered funct3.
REQ-013 decryptedOP  output  4  decoded operation code.
REQ-014 unit_result  input  32  OR of execution-unit registered outputs.
REQ-015 res_valid  output  1  result held for writeback.
REQ-016 res_ready  input  1  writeback accepts result.
REQ-017 res_data  output  32  captured result.
REQ-018 res_illegal  output  1  operation had no valid decode.
REQ-019 op_count  output  16  count of issued legal operations.

Function
REQ-020 decryptedOP SHALL encode: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 8, SRL 12, SRA 13, ILLEGAL 15.
REQ-021 Decode: funct3 000 -> ADD, or SUB when funct7_b5=1 and is_imm=0; 001 -> SLL (illegal if funct7_b5=1); 101 -> SRA if funct7_b5 else SRL; 111/110/100/010/011 -> AND/OR/XOR/SLT/SLTU, funct7_b5 ignored.
REQ-022 Operand 2 source = imm_dat when is_imm=1, else rs2_dat.
REQ-023 For SLL/SRL/SRA, ALU_dat2 SHALL be {27'b0, source[4:0]}; otherwise full 32-bit source.
REQ-024 FSM states IDLE, ISSUE, WAIT, RESP; in_ready=1 only in IDLE.
REQ-025 IDLE: on in_valid, capture operands, ALU_opcode, decryptedOP; go ISSUE if legal, RESP with res_data=0 and res_illegal=1 if ILLEGAL.
REQ-026 ISSUE: dat_ready=1 for exactly this one cycle; next state WAIT; op_count increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-027 WAIT: capture unit_result into res_data at end of cycle; next state RESP.
REQ-028 RESP: res_valid=1, res_data/res_illegal stable until res_ready=1; on res_valid&res_ready return to IDLE.
REQ-029 Latency: acceptance edge cycle 0 -> res_valid first high cycle 3 for legal ops, cycle 1 for illegal.
REQ-030 dat_ready SHALL be 0 in IDLE, WAIT, RESP; operand outputs hold last captured values.
REQ-031 No new operation accepted in RESP even if res_ready=1 in the same cycle (one-cycle bubble).
REQ-032 Input changes outside IDLE SHALL have no effect.

Reset
REQ-033 Reset SHALL force IDLE and zero every output register: dat_ready, ALU_dat1, ALU_dat2, ALU_opcode, decryptedOP, res_valid, res_data, res_illegal, op_count.
REQ-034 Reset mid-operation SHALL abort silently: any pending result discarded without handshake, op_count not incremented for the aborted op.
REQ-035 Reset overrides in_valid and res_ready in the same cycle.

Structure
REQ-036 decryptedOP encodings and FSM state enum SHALL reside in shared package alu_pkg.
REQ-037 Decode logic (REQ-021, REQ-023) SHALL be sub-module alu_op_decode, purely combinational.

Verification
REQ-038 ADD: rs1=5, rs2=7, funct3=000, is_imm=0 -> decryptedOP=0, dat_ready pulse cycle 1, res_data=unit_result captured cycle 2, res_valid cycle 3.
REQ-039 SRAI: rs1=0x80000000, imm=0x00000423, funct3=101, funct7_b5=1 -> ALU_dat2=0x00000003, decryptedOP=13.
REQ-040 Illegal: funct3=001, funct7_b5=1 -> no dat_ready, res_illegal=1, res_data=0, res_valid cycle 1, op_count unchanged.
REQ-041 Backpressure: res_ready=0 for 4 cycles in RESP -> res_data stable, in_ready=0, in_valid ignored.
REQ-042 Reset asserted in WAIT -> next cycle IDLE, all outputs 0, no res_valid.
REQ-043 op_count preloaded via 65535 legal ops -> next legal issue wraps op_count to 0.
